rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a 2-entry queue of
// multi-cycle-unit results, with a starvation-forced drain. Optional macro: RF_ARB_BYPASS_EN.
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_write,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic [1:0]  dbg_state,
  output logic [1:0]  dbg_count
);

  // Handshake: an MDU result transfers on a rising edge where mdu_valid && mdu_ready;
  // mdu_ready depends on the current queue occupancy only, and the producer holds
  // its payload stable while mdu_valid is high and mdu_ready is low.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FORCE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [3:0]  starve_q, starve_d;
  logic [4:0]  fifo_addr_q [2];
  logic [4:0]  fifo_addr_d [2];
  logic [31:0] fifo_data_q [2];
  logic [31:0] fifo_data_d [2];
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  logic pipe_req, in_force, pipe_grant, pop, push, accept, bypass;

  assign pipe_req   = wb_write && (wb_addr != 5'd0);
  assign in_force   = (state_q == ST_FORCE);
  assign mdu_ready  = (count_q < 2'd2);
  assign accept     = mdu_valid && mdu_ready;
  // A forced drain ignores the pipeline entirely, so its request cannot win.
  assign pipe_grant = pipe_req && !in_force;
  assign pop        = (count_q != 2'd0) && !pipe_grant;
`ifdef RF_ARB_BYPASS_EN
  assign bypass     = accept && (count_q == 2'd0) && !pipe_req && !in_force;
`else
  assign bypass     = 1'b0;
`endif
  assign push       = accept && !bypass;

  assign stall_req  = in_force;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign dbg_state  = state_q;
  assign dbg_count  = count_q;

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = mdu_addr;
      fifo_data_d[wr_ptr_q] = mdu_data;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_grant) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_addr;
      rf_wdata_d = wb_data;
    end else if (pop) begin
      // An address-0 entry still uses its slot but never reaches the file.
      rf_we_d    = (fifo_addr_q[rd_ptr_q] != 5'd0);
      rf_waddr_d = fifo_addr_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end else if (bypass) begin
      rf_we_d    = (mdu_addr != 5'd0);
      rf_waddr_d = mdu_addr;
      rf_wdata_d = mdu_data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (in_force || pop || count_q == 2'd0) begin
      starve_d = 4'd0;
    end else if (state_q == ST_PENDING && pipe_grant) begin
      starve_d = starve_q + 4'd1;
    end
    if (!in_force && starve_d == 4'(STARVE_LIMIT)) begin
      state_d = ST_FORCE;
    end else if (count_d != 2'd0) begin
      state_d = ST_PENDING;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      starve_q   <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Queue storage needs no reset: occupancy and pointers gate every read.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: cycle vectors for arbitration/starvation/reset corners,
// random pipeline-only and MDU-only phases, and a write scoreboard.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_count;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  typedef struct {
    logic        rst;
    logic        wbw;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stall;
    logic        ready;
    logic [1:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic wbw, input logic [4:0] wba,
                              input logic [31:0] wbd, input logic mv, input logic [4:0] ma,
                              input logic [31:0] md, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic st, input logic rdy,
                              input logic [1:0] cnt);
    vec_t v;
    v.rst = r; v.wbw = wbw; v.wba = wba; v.wbd = wbd;
    v.mv = mv; v.ma = ma; v.md = md;
    v.we = we; v.wa = wa; v.wd = wd;
    v.stall = st; v.ready = rdy; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; wb_write = v.wbw; wb_addr = v.wba; wb_data = v.wbd;
    mdu_valid = v.mv; mdu_addr = v.ma; mdu_data = v.md;
    if (v.we) exp_q.push_back({v.wa, v.wd});
    @(posedge clk);
    #1;
    check($sformatf("row%0d_we", idx), 32'(rf_we), 32'(v.we));
    check($sformatf("row%0d_stall", idx), 32'(stall_req), 32'(v.stall));
    check($sformatf("row%0d_ready", idx), 32'(mdu_ready), 32'(v.ready));
    check($sformatf("row%0d_count", idx), 32'(dbg_count), 32'(v.cnt));
  endtask

  // Scoreboard: every observed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got write %0d=%0h expected no write", rf_waddr, rf_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          errors++;
          $display("FAIL sb_write: got %0d=%0h expected %0d=%0h",
                   rf_waddr, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    logic        pend;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        ew;
    rst = 1'b1; wb_write = 1'b0; wb_addr = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;

    // reset
    vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 0,1,0));
    vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 0,1,0));
    // single MDU result, no pipeline traffic
`ifdef RF_ARB_BYPASS_EN
    vecs.push_back(mk(0, 0,0,0, 1,5,32'hDEADBEEF, 1,5,32'hDEADBEEF, 0,1,0));
    vecs.push_back(mk(0, 0,0,0, 0,0,0,            0,0,0,            0,1,0));
`else
    vecs.push_back(mk(0, 0,0,0, 1,5,32'hDEADBEEF, 0,0,0,            0,1,1));
    vecs.push_back(mk(0, 0,0,0, 0,0,0,            1,5,32'hDEADBEEF, 0,1,0));
`endif
    // pipeline and MDU in the same cycle
    vecs.push_back(mk(0, 1,3,32'h11, 1,7,32'h22, 1,3,32'h11, 0,1,1));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      1,7,32'h22, 0,1,0));
    // starvation: two queued results, continuous pipeline writes
    vecs.push_back(mk(0, 1,1,32'hA0,  1,10,32'hB0, 1,1,32'hA0,  0,1,1));
    vecs.push_back(mk(0, 1,2,32'hA1,  1,11,32'hB1, 1,2,32'hA1,  0,0,2));
    vecs.push_back(mk(0, 1,3,32'hA2,  0,0,0,       1,3,32'hA2,  0,0,2));
    vecs.push_back(mk(0, 1,4,32'hA3,  0,0,0,       1,4,32'hA3,  0,0,2));
    vecs.push_back(mk(0, 1,5,32'hA4,  0,0,0,       1,5,32'hA4,  1,0,2));
    vecs.push_back(mk(0, 1,6,32'hA5,  0,0,0,       1,10,32'hB0, 0,1,1));
    vecs.push_back(mk(0, 1,7,32'hA6,  0,0,0,       1,7,32'hA6,  0,1,1));
    vecs.push_back(mk(0, 1,8,32'hA7,  0,0,0,       1,8,32'hA7,  0,1,1));
    vecs.push_back(mk(0, 1,9,32'hA8,  0,0,0,       1,9,32'hA8,  0,1,1));
    vecs.push_back(mk(0, 1,10,32'hA9, 0,0,0,       1,10,32'hA9, 1,1,1));
    vecs.push_back(mk(0, 1,11,32'hAA, 0,0,0,       1,11,32'hB1, 0,1,0));
    // full queue with a held third result
    vecs.push_back(mk(0, 1,1,32'hC0, 1,12,32'hD0, 1,1,32'hC0,  0,1,1));
    vecs.push_back(mk(0, 1,2,32'hC1, 1,13,32'hD1, 1,2,32'hC1,  0,0,2));
    vecs.push_back(mk(0, 1,3,32'hC2, 1,14,32'hD2, 1,3,32'hC2,  0,0,2));
    vecs.push_back(mk(0, 0,0,0,      1,14,32'hD2, 1,12,32'hD0, 0,1,1));
    vecs.push_back(mk(0, 0,0,0,      1,14,32'hD2, 1,13,32'hD1, 0,1,1));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,       1,14,32'hD2, 0,1,0));
    // address-0 traffic on both sources
`ifdef RF_ARB_BYPASS_EN
    vecs.push_back(mk(0, 1,0,32'h99, 1,0,32'h77, 0,0,0, 0,1,0));
`else
    vecs.push_back(mk(0, 1,0,32'h99, 1,0,32'h77, 0,0,0, 0,1,1));
`endif
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,0,0, 0,1,0));
    // reset with two queued results
    vecs.push_back(mk(0, 1,4,32'hE0, 1,15,32'hF0, 1,4,32'hE0, 0,1,1));
    vecs.push_back(mk(0, 1,5,32'hE1, 1,16,32'hF1, 1,5,32'hE1, 0,0,2));
    vecs.push_back(mk(1, 1,6,32'hE2, 1,17,32'hF2, 0,0,0,      0,1,0));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,       0,0,0,      0,1,0));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,       0,0,0,      0,1,0));

    foreach (vecs[i]) apply(vecs[i], i);

    // random pipeline-only traffic: a write appears exactly one edge later
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rst = 1'b0; mdu_valid = 1'b0;
      wb_write = 1'($urandom_range(0, 1));
      wb_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data  = $urandom;
      ew = wb_write && (wb_addr != 5'd0);
      if (ew) exp_q.push_back({wb_addr, wb_data});
      @(posedge clk);
      #1;
      check($sformatf("rnd_wb%0d_we", i), 32'(rf_we), 32'(ew));
    end

    // random MDU-only traffic: results must come out in acceptance order
    pend = 1'b0; pa = '0; pd = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wb_write = 1'b0;
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        pa   = 5'($urandom_range(1, 31));
        pd   = $urandom;
      end
      mdu_valid = pend; mdu_addr = pa; mdu_data = pd;
      if (pend && mdu_ready) begin
        exp_q.push_back({pa, pd});
        pend = 1'b0;
      end
    end
    @(negedge clk);
    mdu_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    check("drain_count", 32'(dbg_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
